// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the chunk-serial ALU adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_DEFAULT_WIDTH = 32;
    localparam int c_DEFAULT_CHUNK = 4;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width for the chunk index; a single-chunk build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_adder_if.sv
// ============================================================================
// Module      : multicycle_adder_if
// Description : Start/done handshake and operand/result bus of the adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_adder_if
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) ();

    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, cin, A, B,
        input  ready, busy, done, result, c_out, overflow, zero
    );

    modport slave (
        input  start, sub, cin, A, B,
        output ready, busy, done, result, c_out, overflow, zero
    );

endinterface

`default_nettype wire

// File: rtl/rca_chunk.sv
// ============================================================================
// Module      : rca_chunk
// Description : Combinational N-bit ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb
);

    always_comb begin
        logic w_c;
        w_c   = ci;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < N; i++) begin
            // c_msb is the carry arriving at the top bit, needed for signed overflow
            if (i == N - 1) begin
                c_msb = w_c;
            end
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_adder.sv
// ============================================================================
// Module      : multicycle_adder
// Description : Chunk-serial adder/subtractor, CHUNK bits per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CHUNK = c_DEFAULT_CHUNK
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_adder_if.slave  bus
);

    localparam int                 c_NCHUNK   = nchunk(WIDTH, CHUNK);
    localparam int                 c_IDX_W    = idx_width(c_NCHUNK);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_c_out;
    logic               r_overflow;
    logic               r_zero;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_co;
    logic               w_c_msb;
    logic               w_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_last;

    assign w_accept = w_ready & bus.start;
    assign w_last   = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_ready      = 1'b1;
                w_done       = 1'b1;
                w_state_next = bus.start ? RUN : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < c_NCHUNK; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    rca_chunk #(
        .N (CHUNK)
    ) u_rca (
        .a     (w_a_chunk),
        .b     (w_b_chunk),
        .ci    (r_carry),
        .s     (w_sum),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    // Full word as it will look after this chunk lands; zero is judged on this.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < c_NCHUNK; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_acc_next[k*CHUNK +: CHUNK] = w_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_result   <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            // Subtraction becomes A + ~B + ~cin, so the datapath only ever adds.
            r_idx   <= '0;
            r_a     <= bus.A;
            r_b     <= bus.sub ? ~bus.B : bus.B;
            r_carry <= bus.cin ^ bus.sub;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_co;
            r_idx   <= r_idx + c_IDX_W'(1);
            if (w_last) begin
                r_result   <= w_acc_next;
                r_c_out    <= w_co;
                r_overflow <= w_co ^ w_c_msb;
                r_zero     <= (w_acc_next == '0);
            end
        end
    end

    assign bus.ready    = w_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;
    assign bus.c_out    = r_c_out;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule

`default_nettype wire

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, chunk-serial adder/subtractor for the CPU datapath ALU.
- Adds WIDTH-bit operands CHUNK bits per clock, carry rippling between chunks through a carry register.
- Trades latency for area and a short critical path.
- Start/done handshake toward the ALU control FSM; produces carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- start  input  1  request new operation; sampled only while ready=1.
- sub  input  1  0 = add, 1 = subtract; latched on accepted start.
- cin  input  1  add: carry-in; sub: borrow-in; latched on accepted start.
- A  input  WIDTH  operand A; latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- ready  output  1  block can accept start (state IDLE or DONE).
- busy  output  1  operation in progress (state RUN).
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  sum or difference; held until next accepted start.
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (async assert, rst_n low):
  - state=IDLE; chunk index=0.
  - result=0, c_out=0, overflow=0, zero=0, done=0, busy=0, ready=1.
- Arithmetic:
  - sub=0: result = A + B + cin.
  - sub=1: result = A + ~B + ~cin, i.e. A - B - cin.
  - Operand and carry inversion are applied at latch time.
  - overflow = carry into MSB XOR carry out of MSB, computed in the final chunk.
  - zero is evaluated on the full assembled result when entering DONE.
- States:
  - IDLE: ready=1. Accepted start latches A, effective B and effective carry; chunk index=0; go to RUN.
  - RUN: busy=1, ready=0. Each edge adds chunk[idx] of A and effective B plus the carry register, writes result bits [idx*CHUNK +: CHUNK], updates the carry register, idx+1. After the chunk with idx=NCHUNK-1 (NCHUNK=WIDTH/CHUNK): go to DONE and register c_out, overflow, zero.
  - DONE: done=1 for exactly this cycle, ready=1. start=1 here is accepted as in IDLE (back-to-back, no bubble) and goes to RUN. Otherwise go to IDLE.
- Latency: done is asserted exactly NCHUNK cycles after the edge that accepts start. Throughput is one operation per NCHUNK cycles.
- start while busy=1 is ignored: no latch, no error, in-flight operation unaffected.
- result and the flags are undefined-but-stable during RUN; they are only valid when done=1 and in the following IDLE cycles.
- Reset asserted mid-RUN aborts the operation; outputs return to reset values immediately (async). The first accepted start after reset behaves normally.
- CHUNK=WIDTH degenerates to single-chunk operation: done one cycle after start.

Decomposition:
- Shared package alu_pkg:
  - state enum: IDLE, RUN, DONE.
  - default WIDTH/CHUNK constants.
  - NCHUNK derivation helper.
- Sub-module rca_chunk:
  - combinational CHUNK-bit ripple-carry adder, parameter N.
  - inputs a, b, ci; outputs s, co, and c_msb (carry into MSB, used for overflow).
  - instantiated once and fed by the chunk mux.

Test Plan (WIDTH=32, CHUNK=4, NCHUNK=8):
- Reset: hold rst_n=0 -> ready=1, busy=0, done=0, result=0, c_out=0, overflow=0, zero=0. Assert rst_n low asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Add wrap: A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0 -> done exactly 8 cycles after start; result=0x00000000, c_out=1, zero=1, overflow=0.
- Signed overflow add: A=0x7FFFFFFF, B=1, sub=0, cin=0 -> result=0x80000000, overflow=1, c_out=0, zero=0.
- Subtract, with and without overflow:
  - A=5, B=7, sub=1, cin=0 -> result=0xFFFFFFFE, c_out=0, overflow=0.
  - A=0x80000000, B=1, sub=1 -> result=0x7FFFFFFF, c_out=1, overflow=1.
  - A=10, B=3, sub=1, cin=1 -> result=6.
- Handshake:
  - start pulsed 3 cycles into RUN with A=B=0x11111111 -> ignored; first result unchanged; done still at cycle 8.
  - start held in the DONE cycle with A=1, B=2 -> accepted; second done 8 cycles later with result=3.
- Abort and degenerate config:
  - rst_n low at RUN cycle 4 -> all outputs reset, ready=1; new op A=2, B=2 completes with result=4.
  - Rerun with CHUNK=32 -> done 1 cycle after start, same arithmetic results.
